// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2^MUL_STEP shift-add multiplier
// and restoring radix-2 divider sharing one 2*XLEN accumulator.
module mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic            i_clk_n,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_in_a,
    input  logic [XLEN-1:0] i_in_b,
    input  logic [2:0]      i_funct3,
    input  logic            i_md_en,
    input  logic            i_kill,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid,
    output logic            o_busy
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("mdu_iter: XLEN must be 32 or 64");
    end
    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4)
        || (XLEN % MUL_STEP) != 0) begin : g_bad_step
        $error("mdu_iter: MUL_STEP must be 1, 2 or 4 and divide XLEN");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
    } state_t;

    localparam int CW = 7;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;

    logic                accept, is_div, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]     a_mag, b_mag, byp_res;
    logic [XLEN+MUL_STEP-1:0] pp, psum;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [XLEN:0]       rem_top;
    logic [XLEN-1:0]     diff;
    logic                ge;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, fix_res;

    // Operand conditioning at accept time
    always_comb begin
        is_div  = i_funct3[2];
        a_neg   = i_in_a[XLEN-1]
                  & (i_funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
        b_neg   = i_in_b[XLEN-1]
                  & (i_funct3 inside {3'b001, 3'b100, 3'b110});
        a_mag   = a_neg ? -i_in_a : i_in_a;
        b_mag   = b_neg ? -i_in_b : i_in_b;
        div0    = is_div && (i_in_b == '0);
        ovf     = is_div && !i_funct3[0]
                  && (i_in_a == MIN_VAL) && (i_in_b == '1);
        byp_res = '0;
        if (div0) begin
            byp_res = i_funct3[1] ? i_in_a : '1;
        end else if (ovf) begin
            byp_res = i_funct3[1] ? '0 : i_in_a;
        end
    end

    // One multiply step: add partial product into the high half, shift right
    always_comb begin
        pp       = {{MUL_STEP{1'b0}}, opb_q}
                   * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
        psum     = pp + {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        mul_next = {psum, acc_q[XLEN-1:MUL_STEP]};
    end

    // One restoring divide step: {rem, quotient/dividend} shifted left
    always_comb begin
        rem_top  = acc_q[2*XLEN-1:XLEN-1];
        ge       = rem_top >= {1'b0, opb_q};
        diff     = rem_top[XLEN-1:0] - opb_q;
        div_next = {ge ? diff : rem_top[XLEN-1:0], acc_q[XLEN-2:0], ge};
    end

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (!f3_q[2]) begin
            fix_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                           : prod_s[2*XLEN-1:XLEN];
        end else begin
            fix_res = f3_q[1] ? rem_s : quo_s;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        accept  = (state_q == S_IDLE || state_q == S_DONE)
                  && i_md_en && !i_kill;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    f3_d  = i_funct3;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    opb_d = b_mag;
                    acc_d = {{XLEN{1'b0}}, a_mag};
                    if (div0 || ovf) begin
                        res_d   = byp_res;
                        state_d = S_DONE;
                    end else if (is_div) begin
                        cnt_d   = DIV_LAST;
                        state_d = S_DIV;
                    end else begin
                        cnt_d   = MUL_LAST;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = (state_q == S_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_n) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    assign o_result = res_q;
    assign o_valid  = (state_q == S_DONE);
    assign o_busy   = (state_q == S_MUL) || (state_q == S_DIV)
                      || (state_q == S_FIX);

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32, MUL_STEP=2): directed table,
// multi-cycle corner sequences and random ops against an arithmetic model.
module tb_mdu_iter;

    logic        i_clk_n = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_in_a = '0;
    logic [31:0] i_in_b = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_md_en = 1'b0;
    logic        i_kill = 1'b0;
    logic [31:0] o_result;
    logic        o_valid;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_exp = '0;

    mdu_iter #(.XLEN(32), .MUL_STEP(2)) dut (
        .i_clk_n (i_clk_n),
        .i_rst   (i_rst),
        .i_in_a  (i_in_a),
        .i_in_b  (i_in_b),
        .i_funct3(i_funct3),
        .i_md_en (i_md_en),
        .i_kill  (i_kill),
        .o_result(o_result),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    always #5 i_clk_n = ~i_clk_n;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    function automatic logic [31:0] ref_res(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [31:0] r;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: r = (b == 0) ? a : 32'(sa % sb);
            default: r = (b == 0) ? a : 32'(ua % ub);
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return 18;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_valid(output int cyc, output bit busy_ok);
        bit done = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!done) begin
            @(negedge i_clk_n);
            cyc++;
            if (o_valid === 1'b1 || cyc >= 200) done = 1'b1;
            else if (o_busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b);
        i_funct3 = f3;
        i_in_a   = a;
        i_in_b   = b;
        i_md_en  = 1'b1;
        @(posedge i_clk_n);
        #1;
        i_md_en  = 1'b0;
        i_in_a   = $urandom;
        i_in_b   = $urandom;
        i_funct3 = 3'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input string nm);
        int cyc;
        bit bok;
        @(negedge i_clk_n);
        start_op(f3, a, b);
        wait_valid(cyc, bok);
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " result"}, o_result, exp);
        chk({nm, " busy_at_valid"}, {31'b0, o_busy}, 32'd0);
        if (lat > 1) chk({nm, " busy_during"}, {31'b0, bok}, 32'd1);
        @(negedge i_clk_n);
        chk({nm, " valid_drop"}, {31'b0, o_valid}, 32'd0);
        chk({nm, " result_hold"}, o_result, exp);
        last_exp = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t vt[$];
        int   cyc;
        bit   bok;

        vt.push_back('{3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 18, "mul"});
        vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, "mulh"});
        vt.push_back('{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, "mulhu"});
        vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 18, "mulhsu"});
        vt.push_back('{3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34, "div"});
        vt.push_back('{3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34, "rem"});
        vt.push_back('{3'd5, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, "divu_by0"});
        vt.push_back('{3'd7, 32'h5, 32'h0, 32'h5, 1, "remu_by0"});
        vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"});
        vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf"});
        vt.push_back('{3'd5, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 34, "divu_max"});
        vt.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34, "remu"});

        repeat (2) @(negedge i_clk_n);
        chk("reset_result", o_result, 32'h0);
        chk("reset_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_busy", {31'b0, o_busy}, 32'd0);
        i_rst = 1'b0;

        foreach (vt[i]) run_op(vt[i].f3, vt[i].a, vt[i].b,
                               vt[i].exp, vt[i].lat, vt[i].nm);

        // Kill mid-divide, then a multiply accepted on the next edge
        @(negedge i_clk_n);
        start_op(3'd4, 32'd1000, 32'd7);
        repeat (10) @(negedge i_clk_n);
        chk("kill_busy_before", {31'b0, o_busy}, 32'd1);
        i_kill = 1'b1;
        @(posedge i_clk_n);
        #1;
        i_kill = 1'b0;
        @(negedge i_clk_n);
        chk("kill_busy", {31'b0, o_busy}, 32'd0);
        chk("kill_valid", {31'b0, o_valid}, 32'd0);
        chk("kill_result_hold", o_result, last_exp);
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cyc, bok);
        chk("post_kill_latency", 32'(cyc), 32'd18);
        chk("post_kill_result", o_result, 32'hFFFF_FFFE);

        // Back-to-back accept from DONE, then kill suppressing accept in DONE
        @(negedge i_clk_n);
        start_op(3'd0, 32'h7, 32'hFFFF_FFFD);
        wait_valid(cyc, bok);
        chk("b2b_first", o_result, 32'hFFFF_FFEB);
        start_op(3'd4, 32'hFFFF_FFF9, 32'h2);
        wait_valid(cyc, bok);
        chk("b2b_latency", 32'(cyc), 32'd34);
        chk("b2b_busy", {31'b0, bok}, 32'd1);
        chk("b2b_result", o_result, 32'hFFFF_FFFD);
        i_funct3 = 3'd0;
        i_md_en  = 1'b1;
        i_kill   = 1'b1;
        @(posedge i_clk_n);
        #1;
        i_md_en  = 1'b0;
        i_kill   = 1'b0;
        @(negedge i_clk_n);
        chk("done_kill_busy", {31'b0, o_busy}, 32'd0);
        chk("done_kill_valid", {31'b0, o_valid}, 32'd0);
        chk("done_kill_hold", o_result, 32'hFFFF_FFFD);

        // Reset mid-multiply with start request held high
        start_op(3'd0, 32'h7, 32'h3);
        i_md_en = 1'b1;
        repeat (5) @(negedge i_clk_n);
        i_rst = 1'b1;
        @(negedge i_clk_n);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'h0);
        @(negedge i_clk_n);
        chk("rst_no_accept", {31'b0, o_busy}, 32'd0);
        i_rst   = 1'b0;
        i_md_en = 1'b0;
        @(negedge i_clk_n);
        chk("rst_release_busy", {31'b0, o_busy}, 32'd0);
        last_exp = 32'h0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
